ip2_scanchain_reg: RTL and testbench

Pattern store, shift engine and readback capture for the scan-chain tests. The block holds a 768-bit scan pattern loaded over a 32-bit configuration write port and presents its LSB to the test-1 sequencer as the serial `scan_in` source. It shifts on the sequencer's one-cycle shift pulses, counts the shifts against the fixed test length, and captures the ASIC `scan_out` stream for software readback. It sits directly upstream of the test-1 sequencer: it consumes that sequencer's `load`/`shift` controls and produces its `bit0`, `shift_cnt` and `shift_cnt_max` inputs.

---
 rtl/ip2_scanchain_reg.sv | 165 ++++++++++++++++
 tb/tb_ip2_scanchain_reg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ip2_scanchain_reg.sv
// ---------------------------------------------------------------------------
// ip2_scanchain_reg
//   Scan-pattern store, shift engine and readback capture feeding the test-1
//   sequencer. A CHAIN_LEN-bit pattern is written 32 bits at a time into
//   pat_buf. A load copies it into the work register, whose LSB is the
//   serial scan_in source. Each shift pulse rotates the work register right
//   by one and shifts the synchronized ASIC scan_out into the capture
//   register. Shifts are counted up to SHIFT_LEN-1, where the run is
//   complete and capture_done is raised.
//
// Ports
//   clk, reset                  clock, async active-high reset
//   enable                      block enable, low = synchronous idle
//   cfg_wr_en/addr/data         pattern-buffer word write port
//   scanchain_reg_load          copy pattern to work, clear count/capture
//   scanchain_reg_shift         one-cycle shift pulse
//   scan_out                    ASIC scan-chain output (already synced)
//   rd_addr / rd_data           capture word readback (registered)
//   scanchain_reg_bit0          work-register bit 0
//   scanchain_reg_shift_cnt     shifts since last load (saturating)
//   scanchain_reg_shift_cnt_max constant SHIFT_LEN-1
//   capture_done                count has reached the maximum
// ---------------------------------------------------------------------------
module ip2_scanchain_reg #(
  parameter int CHAIN_LEN = 768,
  parameter int SHIFT_LEN = 2 * CHAIN_LEN,
  parameter int NWORDS    = CHAIN_LEN / 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        cfg_wr_en,
  input  logic [4:0]  cfg_wr_addr,
  input  logic [31:0] cfg_wr_data,
  input  logic        scanchain_reg_load,
  input  logic        scanchain_reg_shift,
  input  logic        scan_out,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        scanchain_reg_bit0,
  output logic [10:0] scanchain_reg_shift_cnt,
  output logic [10:0] scanchain_reg_shift_cnt_max,
  output logic        capture_done
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_SHIFTING = 2'd2;
  localparam logic [1:0] ST_FULL     = 2'd3;

  localparam logic [10:0] CNT_MAX = 11'(SHIFT_LEN - 1);
  // One extra bit so the range compare stays valid for NWORDS == 32.
  localparam logic [5:0]  NW6     = 6'(NWORDS);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [1:0]              state_q, state_d;
  logic [10:0]             cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic [CHAIN_LEN-1:0]    work_q, work_d;
  logic [CHAIN_LEN-1:0]    cap_q, cap_d;
  logic [NWORDS-1:0][31:0] pat_q, pat_d;
  logic [31:0]             rd_data_q, rd_data_d;

  // Word view of the capture register for readback.
  logic [NWORDS-1:0][31:0] cap_words;
  assign cap_words = cap_q;

  logic load_go;
  logic shift_ok;
  logic shift_go;

  // Load has priority over shift. Shifts only count while armed or shifting
  // and never past the maximum, so the counter cannot wrap.
  assign load_go  = enable & scanchain_reg_load;
  assign shift_ok = (state_q == ST_ARMED) | (state_q == ST_SHIFTING);
  assign shift_go = enable & scanchain_reg_shift & ~scanchain_reg_load &
                    shift_ok & (cnt_q != CNT_MAX);

  // ---------------------------------------------------------------------
  // Pattern buffer: config port only, independent of enable and FSM state.
  // ---------------------------------------------------------------------
  always_comb begin
    pat_d = pat_q;
    if (cfg_wr_en && ({1'b0, cfg_wr_addr} < NW6))
      pat_d[cfg_wr_addr] = cfg_wr_data;
  end

  // ---------------------------------------------------------------------
  // FSM, counter, work and capture registers
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    work_d  = work_q;
    cap_d   = cap_q;

    if (!enable) begin
      // work/cap/pat are deliberately kept so software can still read back.
      state_d = ST_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else if (load_go) begin
      state_d = ST_ARMED;
      work_d  = pat_q;
      cnt_d   = '0;
      cap_d   = '0;
      done_d  = 1'b0;
    end else if (shift_go) begin
      work_d = {work_q[0], work_q[CHAIN_LEN-1:1]};
      cap_d  = {scan_out, cap_q[CHAIN_LEN-1:1]};
      cnt_d  = cnt_q + 11'd1;
      if (cnt_d == CNT_MAX) begin
        state_d = ST_FULL;
        done_d  = 1'b1;
      end else begin
        state_d = ST_SHIFTING;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Readback mux
  // ---------------------------------------------------------------------
  always_comb begin
    rd_data_d = '0;
    if ({1'b0, rd_addr} < NW6)
      rd_data_d = cap_words[rd_addr];
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      work_q    <= '0;
      cap_q     <= '0;
      pat_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      work_q    <= work_d;
      cap_q     <= cap_d;
      pat_q     <= pat_d;
      rd_data_q <= rd_data_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign rd_data                     = rd_data_q;
  assign scanchain_reg_bit0          = work_q[0];
  assign scanchain_reg_shift_cnt     = cnt_q;
  assign scanchain_reg_shift_cnt_max = CNT_MAX;
  assign capture_done                = done_q;

endmodule

// File: tb/tb_ip2_scanchain_reg.sv
// Directed bench for ip2_scanchain_reg with hand-computed expectations.
module tb_ip2_scanchain_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        cfg_wr_en;
  logic [4:0]  cfg_wr_addr;
  logic [31:0] cfg_wr_data;
  logic        ld;
  logic        sh;
  logic        scan_out;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        bit0;
  logic [10:0] cnt;
  logic [10:0] cnt_max;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ip2_scanchain_reg dut (
    .clk                         (clk),
    .reset                       (reset),
    .enable                      (enable),
    .cfg_wr_en                   (cfg_wr_en),
    .cfg_wr_addr                 (cfg_wr_addr),
    .cfg_wr_data                 (cfg_wr_data),
    .scanchain_reg_load          (ld),
    .scanchain_reg_shift         (sh),
    .scan_out                    (scan_out),
    .rd_addr                     (rd_addr),
    .rd_data                     (rd_data),
    .scanchain_reg_bit0          (bit0),
    .scanchain_reg_shift_cnt     (cnt),
    .scanchain_reg_shift_cnt_max (cnt_max),
    .capture_done                (done)
  );

  // Stimulus helpers: inputs change 1 ns after a rising edge, outputs are
  // sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic do_load();
    ld = 1'b1;
    tick();
    ld = 1'b0;
  endtask

  task automatic do_shift(input logic so);
    sh = 1'b1; scan_out = so;
    tick();
    sh = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0;
    cfg_wr_data = '0; ld = 1'b0; sh = 1'b0; scan_out = 1'b0; rd_addr = '0;
    repeat (2) tick();
    n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    n_cmp++; if (bit0 !== 1'b0) begin n_bad++; $display("FAIL reset_bit0 got %b exp 0", bit0); end
    n_cmp++; if (cnt !== 11'd0) begin n_bad++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
    n_cmp++; if (cnt_max !== 11'd1535) begin n_bad++; $display("FAIL reset_cnt_max got %0d exp 1535", cnt_max); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", done); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_rotate();
    wr(5'd0, 32'h0000_0005);
    for (int a = 1; a < 24; a++) wr(5'(a), 32'h0);
    do_load();
    n_cmp++; if (bit0 !== 1'b1) begin n_bad++; $display("FAIL rot_load_bit0 got %b exp 1", bit0); end
    n_cmp++; if (cnt !== 11'd0) begin n_bad++; $display("FAIL rot_load_cnt got %0d exp 0", cnt); end
    do_shift(1'b0);
    n_cmp++; if (bit0 !== 1'b0 || cnt !== 11'd1) begin n_bad++; $display("FAIL rot_shift1 got bit0=%b cnt=%0d exp 0/1", bit0, cnt); end
    do_shift(1'b0);
    n_cmp++; if (bit0 !== 1'b1 || cnt !== 11'd2) begin n_bad++; $display("FAIL rot_shift2 got bit0=%b cnt=%0d exp 1/2", bit0, cnt); end
    repeat (766) do_shift(1'b0);
    n_cmp++; if (bit0 !== 1'b1 || cnt !== 11'd768) begin n_bad++; $display("FAIL rot_shift768 got bit0=%b cnt=%0d exp 1/768", bit0, cnt); end
  endtask

  task automatic test_full_run();
    do_load();
    for (int i = 0; i < 1535; i++) begin
      do_shift((i % 2) == 1);
      if (i == 1533) begin
        n_cmp++; if (done !== 1'b0 || cnt !== 11'd1534) begin n_bad++; $display("FAIL full_pre_done got done=%b cnt=%0d exp 0/1534", done, cnt); end
      end
    end
    n_cmp++; if (done !== 1'b1 || cnt !== 11'd1535) begin n_bad++; $display("FAIL full_done got done=%b cnt=%0d exp 1/1535", done, cnt); end
    // 1535 mod 768 = 767, bit 767 of the pattern is 0
    n_cmp++; if (bit0 !== 1'b0) begin n_bad++; $display("FAIL full_bit0 got %b exp 0", bit0); end
    do_shift(1'b1);
    n_cmp++; if (cnt !== 11'd1535 || bit0 !== 1'b0 || done !== 1'b1) begin n_bad++; $display("FAIL full_extra_shift got cnt=%0d bit0=%b done=%b exp 1535/0/1", cnt, bit0, done); end
    // Registered readback: rd_data holds until the next edge.
    rd_addr = 5'd24;
    tick();
    rd_addr = 5'd5;
    n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL full_rd_latency got %h exp 0", rd_data); end
    // cap[j] = sample 767+j, odd index -> 1 on even j
    for (int k = 0; k < 24; k++) begin
      rd_addr = 5'(k);
      tick();
      n_cmp++; if (rd_data !== 32'h5555_5555) begin n_bad++; $display("FAIL full_rd word=%0d got %h exp 55555555", k, rd_data); end
    end
  endtask

  task automatic test_load_shift();
    do_load();
    repeat (100) do_shift(1'b0);
    n_cmp++; if (cnt !== 11'd100) begin n_bad++; $display("FAIL ls_cnt100 got %0d exp 100", cnt); end
    ld = 1'b1; sh = 1'b1; scan_out = 1'b1;
    tick();
    ld = 1'b0; sh = 1'b0;
    n_cmp++; if (cnt !== 11'd0 || bit0 !== 1'b1) begin n_bad++; $display("FAIL ls_collide got cnt=%0d bit0=%b exp 0/1", cnt, bit0); end
    do_shift(1'b0);
    n_cmp++; if (cnt !== 11'd1 || bit0 !== 1'b0) begin n_bad++; $display("FAIL ls_after got cnt=%0d bit0=%b exp 1/0", cnt, bit0); end
    rd_addr = 5'd23;
    tick();
    n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL ls_cap23 got %h exp 0", rd_data); end
  endtask

  task automatic test_enable_drop();
    do_load();
    repeat (300) do_shift(1'b0);
    n_cmp++; if (cnt !== 11'd300) begin n_bad++; $display("FAIL en_cnt300 got %0d exp 300", cnt); end
    enable = 1'b0;
    tick();
    n_cmp++; if (cnt !== 11'd0 || done !== 1'b0) begin n_bad++; $display("FAIL en_drop got cnt=%0d done=%b exp 0/0", cnt, done); end
    do_load();
    repeat (3) do_shift(1'b0);
    // work is retained at rotation 300 (bit 0), load and shifts ignored
    n_cmp++; if (cnt !== 11'd0 || bit0 !== 1'b0) begin n_bad++; $display("FAIL en_low_ignore got cnt=%0d bit0=%b exp 0/0", cnt, bit0); end
    enable = 1'b1;
    repeat (3) do_shift(1'b0);
    n_cmp++; if (cnt !== 11'd0) begin n_bad++; $display("FAIL en_idle_shift got cnt=%0d exp 0", cnt); end
    do_load();
    n_cmp++; if (cnt !== 11'd0 || bit0 !== 1'b1) begin n_bad++; $display("FAIL en_reload got cnt=%0d bit0=%b exp 0/1", cnt, bit0); end
    do_shift(1'b0);
    do_shift(1'b0);
    n_cmp++; if (cnt !== 11'd2 || bit0 !== 1'b1) begin n_bad++; $display("FAIL en_restart got cnt=%0d bit0=%b exp 2/1", cnt, bit0); end
  endtask

  task automatic test_out_of_range();
    int errs;
    logic expb;
    logic [31:0] expw;
    for (int a = 24; a < 32; a++) wr(5'(a), 32'hFFFF_FFFF);
    do_load();
    errs = 0;
    for (int i = 1; i <= 768; i++) begin
      do_shift((((i - 1) >> 5) % 3) == 0);
      expb = ((i % 768) == 0) || ((i % 768) == 2);
      if (bit0 !== expb) errs++;
    end
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL oob_pattern got %0d bad bits exp 0", errs); end
    for (int k = 0; k < 24; k++) begin
      rd_addr = 5'(k);
      tick();
      expw = ((k % 3) == 0) ? 32'hFFFF_FFFF : 32'h0;
      n_cmp++; if (rd_data !== expw) begin n_bad++; $display("FAIL oob_cap word=%0d got %h exp %h", k, rd_data, expw); end
    end
    rd_addr = 5'd24;
    tick();
    n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL oob_rd24 got %h exp 0", rd_data); end
  endtask

  task automatic test_async_reset();
    do_load();
    repeat (500) do_shift(1'b1);
    n_cmp++; if (cnt !== 11'd500) begin n_bad++; $display("FAIL ar_cnt500 got %0d exp 500", cnt); end
    rd_addr = 5'd23;
    tick();
    n_cmp++; if (rd_data !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL ar_cap23 got %h exp ffffffff", rd_data); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (cnt !== 11'd0 || rd_data !== 32'h0 || done !== 1'b0) begin n_bad++; $display("FAIL ar_async got cnt=%0d rd=%h done=%b exp 0/0/0", cnt, rd_data, done); end
    tick();
    reset = 1'b0;
    tick();
    do_load();
    n_cmp++; if (bit0 !== 1'b0 || cnt_max !== 11'd1535) begin n_bad++; $display("FAIL ar_pat_clear got bit0=%b max=%0d exp 0/1535", bit0, cnt_max); end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_full_run();
    test_load_shift();
    test_enable_drop();
    test_out_of_range();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
